// File: rtl/dsa_cmd_fifo.sv
// rtl/dsa_cmd_fifo.sv - first-word-fall-through command FIFO with sticky error flags
module dsa_cmd_fifo #(
  parameter int DSA_CMD_WIDTH = 96,
  parameter int DEPTH_LOG2    = 4,
  parameter int AF_MARGIN     = 2
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  input  logic                     cmd_wr_en,
  input  logic [DSA_CMD_WIDTH-1:0] cmd_wr_data,
  output logic                     cmd_full,
  output logic                     cmd_almost_full,
  input  logic                     dsa_cmd_fifo_rd_en,
  output logic [DSA_CMD_WIDTH-1:0] dsa_xocc_cmd_in,
  output logic                     dsa_cmd_fifo_empty,
  output logic [DEPTH_LOG2:0]      cmd_level,
  output logic                     err_overflow,
  output logic                     err_underflow,
  input  logic                     err_clear
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_AF   = (DEPTH_LOG2 + 1)'(DEPTH - AF_MARGIN);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DSA_CMD_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]    wr_ptr;
  logic [DEPTH_LOG2-1:0]    rd_ptr;
  logic                     push;
  logic                     pop;
  logic                     ovf_event;
  logic                     unf_event;

  // Status flags come only from the registered level, so no path from the request inputs
  assign cmd_full           = (cmd_level == LVL_FULL);
  assign cmd_almost_full    = (cmd_level >= LVL_AF);
  assign dsa_cmd_fifo_empty = (cmd_level == '0);

  // A full FIFO still accepts a push when the same cycle pops, since a slot frees up
  assign push = axi_aresetn & cmd_wr_en & (~cmd_full | dsa_cmd_fifo_rd_en);
  assign pop  = axi_aresetn & dsa_cmd_fifo_rd_en & ~dsa_cmd_fifo_empty;

  assign ovf_event = cmd_wr_en & cmd_full & ~dsa_cmd_fifo_rd_en;
  assign unf_event = dsa_cmd_fifo_rd_en & dsa_cmd_fifo_empty;

  // Head entry falls through; zero while empty so stale storage is never exposed
  assign dsa_xocc_cmd_in = dsa_cmd_fifo_empty ? '0 : mem[rd_ptr];

  // Storage is deliberately not reset; only accepted pushes write it
  always_ff @(posedge axi_aclk) begin
    if (push) mem[wr_ptr] <= cmd_wr_data;
  end

  // Pointers and occupancy
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cmd_level <= cmd_level + LVL_ONE;
        2'b01:   cmd_level <= cmd_level - LVL_ONE;
        default: cmd_level <= cmd_level;
      endcase
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= ovf_event | (err_overflow & ~err_clear);
      err_underflow <= unf_event | (err_underflow & ~err_clear);
    end
  end

endmodule

// File: doc/dsa_cmd_fifo.md
DSA_CMD_FIFO -- requirements
Module: dsa_cmd_fifo

Interface
REQ-001 Parameter DSA_CMD_WIDTH, default 96, SHALL set the command word width in bits.
REQ-002 Parameter DEPTH_LOG2, default 4, SHALL set the FIFO depth to DEPTH = 2^DEPTH_LOG2 entries.
REQ-003 Parameter AF_MARGIN, default 2, SHALL set the almost-full threshold at level >= DEPTH-AF_MARGIN.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports axi_aclk and axi_aresetn.
REQ-005 axi_aclk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-006 axi_aresetn  input  1  SHALL be the asynchronous active-low reset.
REQ-007 cmd_wr_en  input  1  SHALL be the host-side push request.
REQ-008 cmd_wr_data  input  DSA_CMD_WIDTH  SHALL be the command word to push.
REQ-009 cmd_full  output  1  SHALL indicate level == DEPTH.
REQ-010 cmd_almost_full  output  1  SHALL indicate level >= DEPTH-AF_MARGIN.
REQ-011 dsa_cmd_fifo_rd_en  input  1  SHALL be the DSA-side pop request.
REQ-012 dsa_xocc_cmd_in  output  DSA_CMD_WIDTH  SHALL present the head entry (first-word-fall-through).
REQ-013 dsa_cmd_fifo_empty  output  1  SHALL indicate level == 0.
REQ-014 cmd_level  output  DEPTH_LOG2+1  SHALL report the current occupancy, 0..DEPTH.
REQ-015 err_overflow  output  1  SHALL be a sticky flag for a push attempted while full and not popped.
REQ-016 err_underflow  output  1  SHALL be a sticky flag for a pop attempted while empty.
REQ-017 err_clear  input  1  SHALL synchronously clear both sticky error flags.

Function
REQ-018 Storage SHALL be a DEPTH-entry array with write pointer and read pointer, each DEPTH_LOG2 bits, wrapping modulo DEPTH.
REQ-019 A push SHALL be accepted when cmd_wr_en=1 and (cmd_full=0 or dsa_cmd_fifo_rd_en=1); the accepted word is written at wr_ptr and wr_ptr increments.
REQ-020 A pop SHALL be accepted when dsa_cmd_fifo_rd_en=1 and dsa_cmd_fifo_empty=0; rd_ptr increments.
REQ-021 cmd_level SHALL update every cycle as +1 for push only, -1 for pop only, and unchanged for both or neither.
REQ-022 Simultaneous push and pop when full SHALL both be accepted; the level stays DEPTH and err_overflow is not set.
REQ-023 Simultaneous push and pop when empty SHALL accept the push only; the level becomes 1 and err_underflow is set.
REQ-024 dsa_xocc_cmd_in SHALL equal storage[rd_ptr] combinationally when not empty, and all-zero when empty.
REQ-025 Latency: a word pushed at edge N SHALL be visible on dsa_xocc_cmd_in, with dsa_cmd_fifo_empty=0, from cycle N+1.
REQ-026 cmd_full, cmd_almost_full and dsa_cmd_fifo_empty SHALL be registered, or derived from the registered level, with no combinational path from wr_en/rd_en.
REQ-027 err_overflow SHALL set on cmd_wr_en=1 while cmd_full=1 and dsa_cmd_fifo_rd_en=0; the dropped word SHALL NOT corrupt storage or pointers.
REQ-028 err_underflow SHALL set on dsa_cmd_fifo_rd_en=1 while dsa_cmd_fifo_empty=1; pointers SHALL stay unchanged.
REQ-029 If err_clear coincides with a new error event, the flag SHALL end the cycle set (set wins).
REQ-030 Order SHALL be strict FIFO across pointer wrap-around; no entry is duplicated or lost.

Reset
REQ-031 On axi_aresetn=0, asynchronously: pointers=0, cmd_level=0, dsa_cmd_fifo_empty=1, cmd_full=0, cmd_almost_full=0, err_overflow=0, err_underflow=0, dsa_xocc_cmd_in=0.
REQ-032 Storage contents SHALL NOT be reset; a reset mid-operation discards all entries, and the first push after release SHALL land at index 0.
REQ-033 Push and pop requests during reset SHALL be ignored.

Verification (DEPTH_LOG2=4, AF_MARGIN=2)
REQ-034 Push 96'h1 at edge 0, no pop -> cycle 1: empty=0, level=1, dsa_xocc_cmd_in=96'h1.
REQ-035 Push 16 words 1..16 -> full=1, level=16, almost_full=1 from level 14; a 17th push sets err_overflow=1; popping 16 returns 1..16 in order, then empty=1.
REQ-036 With FIFO full, push 0xAA and pop together -> level stays 16, err_overflow=0, and after 16 further pops the last word popped is 0xAA.
REQ-037 Pop while empty -> err_underflow=1 and level=0; err_clear next cycle -> flag 0; err_clear coinciding with a new empty pop -> flag remains 1.
REQ-038 Push 24 words and pop 24 words interleaved (pointer wrap) -> output sequence identical to input; level never exceeds 16.
REQ-039 Reset asserted at level=5 -> immediately empty=1, level=0, output 0; after release, push 0x55 -> output 0x55 next cycle.
